// File: rtl/fw_ctrl_if.sv
// Farm-way controller port bundle.
// The highway side drives the request and car sensor; the farm way answers.
interface fw_ctrl_if;
    logic       invk_fw;
    logic       car_on_fw;
    logic       invk_hw;
    logic [1:0] state_fw;
    logic       lamp_red;
    logic       lamp_green;
    logic       lamp_yellow;
    logic       timer_fw_reset;
    logic       protocol_err;

    modport master (
        output invk_fw,
        output car_on_fw,
        input  invk_hw,
        input  state_fw,
        input  lamp_red,
        input  lamp_green,
        input  lamp_yellow,
        input  timer_fw_reset,
        input  protocol_err
    );

    modport slave (
        input  invk_fw,
        input  car_on_fw,
        output invk_hw,
        output state_fw,
        output lamp_red,
        output lamp_green,
        output lamp_yellow,
        output timer_fw_reset,
        output protocol_err
    );
endinterface

// File: rtl/fw_ctrl.sv
// Farm-way light controller: runs GREEN/YELLOW/RED on request, then hands back.
// Optional early GREEN end when the farm way is empty: FW_EARLY_END_EN.
module fw_ctrl #(
    parameter int SHORT_CYCLES = 4,
    parameter int LONG_CYCLES  = 16,
    parameter int CNT_W        = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    fw_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RED     = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        ILLEGAL = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] SHORT_M1 = CNT_W'(SHORT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(LONG_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             invk_hw_q, invk_hw_d;
    logic             perr_q, perr_d;
    logic             short_to;
    logic             long_to;
    logic             early_end;
    logic             change;

    assign short_to = (cnt_q == SHORT_M1);
    assign long_to  = (cnt_q == LONG_M1);

`ifdef FW_EARLY_END_EN
    assign early_end = !bus.car_on_fw && (cnt_q >= SHORT_M1);
`else
    logic unused_car;
    assign unused_car = bus.car_on_fw;
    assign early_end  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RED:     if (bus.invk_fw)          state_d = GREEN;
            GREEN:   if (long_to || early_end) state_d = YELLOW;
            YELLOW:  if (short_to)             state_d = RED;
            default:                           state_d = RED;
        endcase

        change = (state_d != state_q);

        // Saturate rather than wrap so a long RED idle never fakes a timeout
        if (change)
            cnt_d = '0;
        else if (cnt_q == '1)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;

        invk_hw_d = (state_q == YELLOW) && (state_d == RED);
        perr_d    = perr_q | (bus.invk_fw && (state_q != RED));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RED;
            cnt_q     <= '0;
            invk_hw_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            invk_hw_q <= invk_hw_d;
            perr_q    <= perr_d;
        end
    end

    assign bus.state_fw       = state_q;
    assign bus.lamp_red       = (state_q == RED) || (state_q == ILLEGAL);
    assign bus.lamp_green     = (state_q == GREEN);
    assign bus.lamp_yellow    = (state_q == YELLOW);
    assign bus.timer_fw_reset = reset_n && change;
    assign bus.invk_hw        = invk_hw_q;
    assign bus.protocol_err   = perr_q;

endmodule

// File: tb/tb_fw_ctrl.sv
// Directed bench for fw_ctrl with SHORT_CYCLES=4, LONG_CYCLES=16.
// Expected values come from the cycle-indexed sequence computed below.
module tb_fw_ctrl;

    localparam int LONG_G = 16;
`ifdef FW_EARLY_END_EN
    localparam int EMPTY_G = 4;
`else
    localparam int EMPTY_G = 16;
`endif

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    bit   perr_exp;

    fw_ctrl_if bus ();

    fw_ctrl #(
        .SHORT_CYCLES(4),
        .LONG_CYCLES (16),
        .CNT_W       (8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [2:0] lamps_for(input logic [1:0] s);
        case (s)
            2'd1:    return 3'b010;
            2'd2:    return 3'b001;
            default: return 3'b100;
        endcase
    endfunction

    task automatic check_all(input string tag, input logic [1:0] s,
                             input bit tmr, input bit hw);
        chk({tag, "_state"}, 32'(bus.state_fw), 32'(s));
        chk({tag, "_lamps"},
            32'({bus.lamp_red, bus.lamp_green, bus.lamp_yellow}),
            32'(lamps_for(s)));
        chk({tag, "_timer"}, 32'(bus.timer_fw_reset), 32'(tmr));
        chk({tag, "_invk_hw"}, 32'(bus.invk_hw), 32'(hw));
        chk({tag, "_perr"}, 32'(bus.protocol_err), 32'(perr_exp));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Caller is 1ns into cycle 0 with invk_fw=1 already driven.
    task automatic run_seq(input string tag, input int g, input int err_at,
                           input bit chain, input bit next_car,
                           input bit hw0);
        logic [1:0] s;
        bit         tmr;
        bit         hw;
        for (int i = 0; i <= g + 5; i++) begin
            #1;
            if (i == 0)          s = 2'd0;
            else if (i <= g)     s = 2'd1;
            else if (i <= g + 4) s = 2'd2;
            else                 s = 2'd0;
            tmr = (i == 0) || (i == g) || (i == g + 4) ||
                  (chain && i == g + 5);
            hw  = (i == 0) ? hw0 : (i == g + 5);
            check_all($sformatf("%s_c%0d", tag, i), s, tmr, hw);
            if (i < g + 5) begin
                next_cycle();
                if (err_at > 0 && i == err_at) perr_exp = 1'b1;
                bus.invk_fw = (i + 1 == err_at) ||
                              (chain && i + 1 == g + 5);
                if (chain && i + 1 == g + 5) bus.car_on_fw = next_car;
            end
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        perr_exp    = 1'b0;
        reset_n     = 1'b0;
        bus.invk_fw = 1'b1;
        bus.car_on_fw = 1'b1;

        // In reset with a request present: nothing moves, no timer clear
        #3;
        check_all("rst", 2'd0, 1'b0, 1'b0);
        chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
        bus.invk_fw = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            next_cycle();
            #1;
            check_all($sformatf("idle%0d", i), 2'd0, 1'b0, 1'b0);
        end

        // Full sequence with car present, re-armed in the hand-back cycle
        next_cycle();
        bus.invk_fw   = 1'b1;
        bus.car_on_fw = 1'b1;
        run_seq("full", LONG_G, 0, 1'b1, 1'b0, 1'b0);

        // Empty farm way: early end only when the option is built in
        run_seq("empty", EMPTY_G, 0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            check_all($sformatf("post_empty%0d", i), 2'd0, 1'b0, 1'b0);
        end

        // Stray request during GREEN: sequence unchanged, error sticks
        next_cycle();
        bus.invk_fw   = 1'b1;
        bus.car_on_fw = 1'b1;
        run_seq("err", LONG_G, 5, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #1;
            check_all($sformatf("err_hold%0d", i), 2'd0, 1'b0, 1'b0);
        end

        // Reset asserted in the 10th GREEN cycle
        next_cycle();
        bus.invk_fw = 1'b1;
        next_cycle();
        bus.invk_fw = 1'b0;
        for (int i = 1; i < 10; i++) next_cycle();
        #1;
        chk("mid_state_pre", 32'(bus.state_fw), 32'd1);
        chk("mid_cnt_pre", 32'(dut.cnt_q), 32'd9);
        reset_n = 1'b0;
        perr_exp = 1'b0;
        #1;
        check_all("mid_rst", 2'd0, 1'b0, 1'b0);
        chk("mid_rst_cnt", 32'(dut.cnt_q), 32'd0);
        next_cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            #1;
            check_all($sformatf("after_rst%0d", i), 2'd0, 1'b0, 1'b0);
        end
        bus.invk_fw = 1'b1;
        #1;
        chk("rearm_timer", 32'(bus.timer_fw_reset), 32'd1);
        next_cycle();
        bus.invk_fw = 1'b0;
        #1;
        check_all("rearm_green", 2'd1, 1'b0, 1'b0);
        chk("rearm_cnt", 32'(dut.cnt_q), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fw_ctrl.md
# fw_ctrl

Farm-way light controller: the responder side of the highway/farm-way handshake. It sits opposite the highway controller. It accepts the one-cycle `invk_fw` request that the highway controller raises when it drops to RED. It then runs the farm-way GREEN → YELLOW → RED sequence using its own dwell timer. When the farm way is back at RED, it hands control back with a one-cycle `invk_hw` pulse.

## Interface
Parameters:
- `SHORT_CYCLES`, default 4: YELLOW dwell, and the minimum GREEN dwell when early end is enabled.
- `LONG_CYCLES`, default 16: maximum GREEN dwell.
- `CNT_W`, default 8: dwell counter width. Legal range is 1 ≤ SHORT_CYCLES < LONG_CYCLES ≤ 2^CNT_W.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `invk_fw`  in  1  request from the highway controller, single-cycle pulse.
- `car_on_fw`  in  1  farm-way car sensor, level, synchronous to `clk`.
- `invk_hw`  out  1  hand-back pulse to the highway controller.
- `state_fw`  out  2  current state: RED=2'd0, GREEN=2'd1, YELLOW=2'd2.
- `lamp_red`, `lamp_green`, `lamp_yellow`  out  1 each  one-hot lamp drives decoded from `state_fw`.
- `timer_fw_reset`  out  1  high in any cycle where the dwell counter is cleared.
- `protocol_err`  out  1  sticky flag: `invk_fw` was seen while not in RED.

## Operation
- States: RED, GREEN, YELLOW. Encoding 2'd3 is illegal and goes to RED on the next edge.
- Dwell counter `cnt` (CNT_W bits):
  - clears to 0 on every state change;
  - otherwise increments, saturating at all-ones.
- Derived timeouts:
  - `short_to` = (cnt == SHORT_CYCLES-1)
  - `long_to` = (cnt == LONG_CYCLES-1)
- State transitions:
  - RED: on `invk_fw`=1 go to GREEN; otherwise stay in RED.
  - GREEN: on `long_to` go to YELLOW (see Configuration for early end).
  - YELLOW: on `short_to` go to RED.
- `invk_hw` is registered. It is high for exactly the one cycle following the YELLOW→RED edge.
- `timer_fw_reset` is combinational, equal to the next-state-differs-from-state condition.
- `invk_fw` in GREEN or YELLOW:
  - it is ignored for state purposes;
  - it sets `protocol_err` on the next edge;
  - `protocol_err` clears only on reset.
- `car_on_fw` has no effect in RED or YELLOW. The farm way is serviced only when the highway invokes it.
- Lamps: exactly one lamp is high at all times outside reset. In the illegal state, `lamp_red`=1.

## Timing
- Reset values while `reset_n`=0 (asynchronous):
  - `state_fw`=RED, `cnt`=0;
  - `invk_hw`=0, `protocol_err`=0;
  - `lamp_red`=1, other lamps 0;
  - `timer_fw_reset`=0.
- Reset deasserting mid-sequence always restarts in RED. Any request pending at that moment is lost.
- Request latency: `invk_fw` sampled at edge k gives `state_fw`=GREEN after edge k.
- GREEN lasts exactly LONG_CYCLES cycles, or fewer under early end. YELLOW lasts exactly SHORT_CYCLES cycles.
- Full sequence from the request edge to the `invk_hw` pulse is LONG_CYCLES+SHORT_CYCLES cycles, with `invk_hw` high in the first RED cycle.
- `invk_fw` in that same first RED cycle, i.e. simultaneous with `invk_hw`, is legal. It is accepted and re-enters GREEN on the next edge.
- `cnt` saturating in RED is harmless. No wrap-around is allowed.

## Configuration
- Macro: `FW_EARLY_END_EN`.
- Defined:
  - GREEN also goes to YELLOW when `car_on_fw`=0 and `cnt` ≥ SHORT_CYCLES-1;
  - `long_to` still forces YELLOW.
- Undefined:
  - GREEN always lasts LONG_CYCLES;
  - `car_on_fw` is unused, but the port is kept.

## Test plan
All scenarios use SHORT_CYCLES=4, LONG_CYCLES=16.
- Reset then idle 20 cycles with `invk_fw`=0 → `state_fw`=0 throughout, `lamp_red`=1, `invk_hw`=0, `protocol_err`=0.
- `invk_fw` pulse at edge 0 with `car_on_fw`=1 → GREEN for edges 1–16, YELLOW for edges 17–20, RED at edge 21, `invk_hw`=1 only in cycle 21–22. `timer_fw_reset` is high in cycles 0, 16 and 20.
- With `FW_EARLY_END_EN`: `car_on_fw`=0 throughout, `invk_fw` at edge 0 → YELLOW after edge 4, RED after edge 8, `invk_hw` pulse in the cycle after edge 8. Without the macro, timing matches the previous scenario.
- `invk_fw` pulsed during GREEN (edge 5) → state sequence unchanged, `protocol_err`=1 after edge 5 and held until reset.
- `invk_fw` asserted in the `invk_hw` cycle → GREEN on the following edge, `protocol_err` stays 0.
- `reset_n` driven low at cycle 10 of GREEN → same cycle `state_fw`=0, `lamp_red`=1, `cnt`=0. After release, RED holds until the next `invk_fw`.
